// File: rtl/mips_ctrl_pkg.sv
// Shared types and opcode constants for the multi-cycle MIPS control unit.
// Holds the FSM state, PC/destination selects, instruction classes and a classifier.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_REG    = 2'd3
    } pc_sel_t;

    typedef enum logic [1:0] {
        RD_RT  = 2'd0,
        RD_RD  = 2'd1,
        RD_R31 = 2'd2
    } rd_sel_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_RTYPE,
        CLS_IALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_CTRL
    } inst_class_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    localparam logic [4:0] RI_BLTZ   = 5'h00;
    localparam logic [4:0] RI_BGEZ   = 5'h01;
    localparam logic [4:0] RI_BLTZAL = 5'h10;
    localparam logic [4:0] RI_BGEZAL = 5'h11;

    // JR/JALR live under SPECIAL but are sequenced as control transfers.
    function automatic inst_class_t classify(
        input logic [5:0] op,
        input logic [5:0] fn
    );
        inst_class_t c;
        c = CLS_NOP;
        if (op == OP_SPECIAL) begin
            c = (fn == FN_JR || fn == FN_JALR) ? CLS_CTRL : CLS_RTYPE;
        end else begin
            unique case (op[5:3])
                3'b000:  c = CLS_CTRL;
                3'b001:  c = CLS_IALU;
                3'b100:  c = CLS_LOAD;
                3'b101:  c = CLS_STORE;
                default: c = CLS_NOP;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/mips_branch_resolve.sv
// Combinational branch/jump resolver: condition, redirect kind, link and dest.
// Ports: instr, rs_data, rt_data in; taken, kind, link, rd_sel out.
module mips_branch_resolve
    import mips_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              taken,
    output pc_sel_t           kind,
    output logic              link,
    output rd_sel_t           rd_sel
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    logic       neg;
    logic       zero;
    logic       unused;

    assign op     = instr[31:26];
    assign fn     = instr[5:0];
    assign rt     = instr[20:16];
    assign neg    = rs_data[DATA_W-1];
    assign zero   = (rs_data == '0);
    assign unused = ^{instr[25:21], instr[15:6]};

    always_comb begin
        taken  = 1'b0;
        kind   = PC_PLUS4;
        link   = 1'b0;
        rd_sel = (op == OP_SPECIAL) ? RD_RD : RD_RT;
        unique case (op)
            OP_SPECIAL: begin
                if (fn == FN_JR || fn == FN_JALR) begin
                    taken = 1'b1;
                    kind  = PC_REG;
                    link  = (fn == FN_JALR);
                end
            end
            OP_REGIMM: begin
                kind = PC_BRANCH;
                unique case (rt)
                    RI_BLTZ: taken = neg;
                    RI_BGEZ: taken = !neg;
                    RI_BLTZAL: begin
                        taken  = neg;
                        link   = 1'b1;
                        rd_sel = RD_R31;
                    end
                    RI_BGEZAL: begin
                        taken  = !neg;
                        link   = 1'b1;
                        rd_sel = RD_R31;
                    end
                    default: taken = 1'b0;
                endcase
            end
            OP_J: begin
                taken = 1'b1;
                kind  = PC_JUMP;
            end
            OP_JAL: begin
                taken  = 1'b1;
                kind   = PC_JUMP;
                link   = 1'b1;
                rd_sel = RD_R31;
            end
            OP_BEQ: begin
                kind  = PC_BRANCH;
                taken = (rs_data == rt_data);
            end
            OP_BNE: begin
                kind  = PC_BRANCH;
                taken = (rs_data != rt_data);
            end
            OP_BLEZ: begin
                kind  = PC_BRANCH;
                taken = neg || zero;
            end
            OP_BGTZ: begin
                kind  = PC_BRANCH;
                taken = !neg && !zero;
            end
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with Avalon stalls.
// Ports: clk, reset, instr, waitrequest, rs/rt data in; datapath strobes out.
module mips_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter bit                DELAY_SLOT = 1'b1,
    parameter logic [DATA_W-1:0] HALT_ADDR  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic              addr_sel,
    output logic              ir_load,
    output logic              alu_src,
    output logic [1:0]        rd_sel,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic              link,
    output logic              pc_write,
    output logic [1:0]        pc_sel,
    output logic              active
);

    state_t            state;
    state_t            state_d;
    inst_class_t       cls_q;
    logic              taken_q;
    logic              link_q;
    pc_sel_t           kind_q;
    rd_sel_t           rdsel_q;
    logic [DATA_W-1:0] rs_q;
    logic              pend_q;
    pc_sel_t           pend_kind_q;
    logic              pend_halt_q;
    logic              pend_set;
    logic              pend_clr;
    logic              br_taken;
    logic              br_link;
    pc_sel_t           br_kind;
    rd_sel_t           br_rd_sel;
    logic              halt_cond;

    mips_branch_resolve #(
        .DATA_W(DATA_W)
    ) u_resolve (
        .instr  (instr),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .taken  (br_taken),
        .kind   (br_kind),
        .link   (br_link),
        .rd_sel (br_rd_sel)
    );

    assign halt_cond = taken_q && (kind_q == PC_REG) && (rs_q == HALT_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            cls_q       <= CLS_NOP;
            taken_q     <= 1'b0;
            link_q      <= 1'b0;
            kind_q      <= PC_PLUS4;
            rdsel_q     <= RD_RD;
            rs_q        <= '0;
            pend_q      <= 1'b0;
            pend_kind_q <= PC_PLUS4;
            pend_halt_q <= 1'b0;
        end else begin
            state <= state_d;
            if (state == DECODE) begin
                cls_q   <= classify(instr[31:26], instr[5:0]);
                taken_q <= br_taken;
                link_q  <= br_link;
                kind_q  <= br_kind;
                rdsel_q <= br_rd_sel;
                rs_q    <= rs_data;
            end
            if (pend_clr) begin
                pend_q      <= 1'b0;
                pend_halt_q <= 1'b0;
            end else if (pend_set) begin
                pend_q      <= 1'b1;
                pend_kind_q <= kind_q;
                pend_halt_q <= halt_cond;
            end
        end
    end

    always_comb begin
        state_d    = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr_sel   = 1'b0;
        ir_load    = 1'b0;
        alu_src    = 1'b0;
        rd_sel     = RD_RD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        link       = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = PC_PLUS4;
        active     = 1'b0;
        pend_set   = 1'b0;
        pend_clr   = 1'b0;
        // Reset masks outputs combinationally so a stalled strobe drops at once.
        if (!reset) begin
            unique case (state)
                FETCH: begin
                    active   = 1'b1;
                    mem_read = 1'b1;
                    if (!waitrequest) begin
                        ir_load = 1'b1;
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    active  = 1'b1;
                    state_d = EXEC;
                end
                EXEC: begin
                    active  = 1'b1;
                    alu_src = (cls_q == CLS_LOAD) || (cls_q == CLS_STORE) ||
                              (cls_q == CLS_IALU);
                    if (cls_q == CLS_LOAD || cls_q == CLS_STORE)
                        state_d = MEM;
                    else
                        state_d = WB;
                end
                MEM: begin
                    active    = 1'b1;
                    addr_sel  = 1'b1;
                    mem_read  = (cls_q == CLS_LOAD);
                    mem_write = (cls_q == CLS_STORE);
                    if (!waitrequest)
                        state_d = WB;
                end
                WB: begin
                    active     = 1'b1;
                    pc_write   = 1'b1;
                    rd_sel     = rdsel_q;
                    mem_to_reg = (cls_q == CLS_LOAD);
                    link       = link_q;
                    reg_write  = (cls_q == CLS_RTYPE) || (cls_q == CLS_IALU) ||
                                 (cls_q == CLS_LOAD) || link_q;
                    state_d    = FETCH;
                    // A pending redirect overrides any branch in its slot.
                    if (pend_q) begin
                        pc_sel   = pend_kind_q;
                        pend_clr = 1'b1;
                        if (pend_halt_q)
                            state_d = HALT;
                    end else if (taken_q) begin
                        if (DELAY_SLOT) begin
                            pend_set = 1'b1;
                        end else begin
                            pc_sel = kind_q;
                            if (halt_cond)
                                state_d = HALT;
                        end
                    end
                end
                HALT: state_d = HALT;
                default: state_d = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench for mips_control_fsm: one DUT with a delay slot, one without.
// Expected control words are queued per cycle and popped at the falling edge.
module tb_mips_control_fsm;

    localparam int DW = 32;

    localparam logic [31:0] I_ADDU   = 32'h0022_1821;
    localparam logic [31:0] I_ADDIU  = 32'h2424_0001;
    localparam logic [31:0] I_LW     = 32'h8C25_0000;
    localparam logic [31:0] I_SW     = 32'hAC25_0004;
    localparam logic [31:0] I_UNK    = 32'hFC00_0000;
    localparam logic [31:0] I_BGEZAL = 32'h0431_0004;
    localparam logic [31:0] I_BEQ    = 32'h1022_0004;
    localparam logic [31:0] I_JR     = 32'h0020_0008;

    typedef struct packed {
        logic [13:0] v;
        logic [13:0] m;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst1;
    logic          rst0;
    logic          waitrequest;
    logic [31:0]   instr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    wire  [13:0]   obs1;
    wire  [13:0]   obs0;

    int   checks   = 0;
    int   failures = 0;
    exp_t q1[$];
    exp_t q0[$];
    string tq[$];

    always #5 clk = ~clk;

    // Word layout: active rd wr asel irl alu rdsel[2] rw m2r lnk pcw pcsel[2]
    mips_control_fsm #(
        .DATA_W(DW), .DELAY_SLOT(1'b1), .HALT_ADDR('0)
    ) dut1 (
        .clk(clk), .reset(rst1), .instr(instr), .waitrequest(waitrequest),
        .rs_data(rs_data), .rt_data(rt_data),
        .mem_read(obs1[12]), .mem_write(obs1[11]), .addr_sel(obs1[10]),
        .ir_load(obs1[9]), .alu_src(obs1[8]), .rd_sel(obs1[7:6]),
        .reg_write(obs1[5]), .mem_to_reg(obs1[4]), .link(obs1[3]),
        .pc_write(obs1[2]), .pc_sel(obs1[1:0]), .active(obs1[13])
    );

    mips_control_fsm #(
        .DATA_W(DW), .DELAY_SLOT(1'b0), .HALT_ADDR('0)
    ) dut0 (
        .clk(clk), .reset(rst0), .instr(instr), .waitrequest(waitrequest),
        .rs_data(rs_data), .rt_data(rt_data),
        .mem_read(obs0[12]), .mem_write(obs0[11]), .addr_sel(obs0[10]),
        .ir_load(obs0[9]), .alu_src(obs0[8]), .rd_sel(obs0[7:6]),
        .reg_write(obs0[5]), .mem_to_reg(obs0[4]), .link(obs0[3]),
        .pc_write(obs0[2]), .pc_sel(obs0[1:0]), .active(obs0[13])
    );

    function automatic exp_t cw(
        input logic act, mr, mw, asel, irl, als,
        input logic [1:0] rds,
        input logic rw, m2r, lk, pw,
        input logic [1:0] pcs,
        input logic rdc
    );
        exp_t e;
        e.v = {act, mr, mw, asel, irl, als, rds, rw, m2r, lk, pw, pcs};
        e.m = 14'h3FFF;
        if (!rdc)
            e.m[7:6] = 2'b00;
        return e;
    endfunction

    function automatic exp_t rst_w();
        return cw(0, 0, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0, 2'd0, 1);
    endfunction
    function automatic exp_t fet(input logic w);
        return cw(1, 1, 0, 0, !w, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
    endfunction
    function automatic exp_t dec();
        return cw(1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
    endfunction
    function automatic exp_t exe(input logic als);
        return cw(1, 0, 0, 0, 0, als, 2'd0, 0, 0, 0, 0, 2'd0, 0);
    endfunction
    function automatic exp_t mem(input logic r, input logic w);
        return cw(1, r, w, 1, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
    endfunction
    function automatic exp_t wbw(
        input logic [1:0] rds, input logic rw, m2r, lk, input logic [1:0] pcs
    );
        return cw(1, 0, 0, 0, 0, 0, rds, rw, m2r, lk, 1, pcs, rw);
    endfunction
    function automatic exp_t hlt();
        return cw(0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
    endfunction

    task automatic step(
        input string tag, input logic r1, r0, wr, input exp_t e1, e0
    );
        exp_t a;
        exp_t b;
        string t;
        rst1        = r1;
        rst0        = r0;
        waitrequest = wr;
        q1.push_back(e1);
        q0.push_back(e0);
        tq.push_back(tag);
        @(negedge clk);
        a = q1.pop_front();
        b = q0.pop_front();
        t = tq.pop_front();
        checks++;
        assert ((obs1 & a.m) === (a.v & a.m)) else begin
            failures++;
            $error("FAIL %s ds1 observed=%h expected=%h", t, obs1 & a.m, a.v & a.m);
        end
        checks++;
        assert ((obs0 & b.m) === (b.v & b.m)) else begin
            failures++;
            $error("FAIL %s ds0 observed=%h expected=%h", t, obs0 & b.m, b.v & b.m);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic s1(input string tag, input logic wr, input exp_t e);
        step(tag, 1'b0, 1'b1, wr, e, rst_w());
    endtask

    task automatic s0(input string tag, input logic wr, input exp_t e);
        step(tag, 1'b1, 1'b0, wr, rst_w(), e);
    endtask

    task automatic load(input logic [31:0] i, input logic [DW-1:0] rs, rt);
        instr   = i;
        rs_data = rs;
        rt_data = rt;
    endtask

    initial begin
        rst1 = 1'b1;
        rst0 = 1'b1;
        waitrequest = 1'b0;
        load(I_ADDU, 32'd1, 32'd2);
        @(posedge clk);
        #1;
        step("reset", 1, 1, 1, rst_w(), rst_w());

        s1("addu_f", 0, fet(0));
        s1("addu_d", 0, dec());
        s1("addu_e", 0, exe(0));
        s1("addu_wb", 0, wbw(2'd1, 1, 0, 0, 2'd0));

        load(I_ADDIU, 32'd1, 32'd0);
        s1("addiu_f", 0, fet(0));
        s1("addiu_d", 0, dec());
        s1("addiu_e", 0, exe(1));
        s1("addiu_wb", 0, wbw(2'd0, 1, 0, 0, 2'd0));

        load(I_LW, 32'h100, 32'd0);
        s1("lw_fwait", 1, fet(1));
        s1("lw_f", 0, fet(0));
        s1("lw_d", 0, dec());
        s1("lw_e", 0, exe(1));
        s1("lw_m0", 1, mem(1, 0));
        s1("lw_m1", 1, mem(1, 0));
        s1("lw_m2", 1, mem(1, 0));
        s1("lw_m3", 0, mem(1, 0));
        s1("lw_wb", 0, wbw(2'd0, 1, 1, 0, 2'd0));

        load(I_SW, 32'h100, 32'h55);
        s1("sw_f", 0, fet(0));
        s1("sw_d", 0, dec());
        s1("sw_e", 0, exe(1));
        s1("sw_m0", 1, mem(0, 1));
        s1("sw_m1", 0, mem(0, 1));
        s1("sw_wb", 0, wbw(2'd0, 0, 0, 0, 2'd0));

        load(I_UNK, 32'd0, 32'd0);
        s1("unk_f", 0, fet(0));
        s1("unk_d", 0, dec());
        s1("unk_e", 0, exe(0));
        s1("unk_wb", 0, wbw(2'd0, 0, 0, 0, 2'd0));

        load(I_BGEZAL, 32'h8000_0000, 32'd0);
        s1("bgezal_nt_f", 0, fet(0));
        s1("bgezal_nt_d", 0, dec());
        s1("bgezal_nt_e", 0, exe(0));
        s1("bgezal_nt_wb", 0, wbw(2'd2, 1, 0, 1, 2'd0));
        load(I_ADDU, 32'd0, 32'd0);
        s1("after_nt_f", 0, fet(0));
        s1("after_nt_d", 0, dec());
        s1("after_nt_e", 0, exe(0));
        s1("after_nt_wb", 0, wbw(2'd1, 1, 0, 0, 2'd0));

        load(I_BGEZAL, 32'h0000_8000, 32'd0);
        s1("bgezal_t_f", 0, fet(0));
        s1("bgezal_t_d", 0, dec());
        s1("bgezal_t_e", 0, exe(0));
        s1("bgezal_t_wb", 0, wbw(2'd2, 1, 0, 1, 2'd0));
        load(I_ADDU, 32'd0, 32'd0);
        s1("slot1_f", 0, fet(0));
        s1("slot1_d", 0, dec());
        s1("slot1_e", 0, exe(0));
        s1("slot1_wb", 0, wbw(2'd1, 1, 0, 0, 2'd1));

        load(I_BEQ, 32'd5, 32'd5);
        s1("beq_f", 0, fet(0));
        s1("beq_d", 0, dec());
        s1("beq_e", 0, exe(0));
        s1("beq_wb", 0, wbw(2'd0, 0, 0, 0, 2'd0));
        load(I_BGEZAL, 32'h10, 32'd0);
        s1("slotbr_f", 0, fet(0));
        s1("slotbr_d", 0, dec());
        s1("slotbr_e", 0, exe(0));
        s1("slotbr_wb", 0, wbw(2'd2, 1, 0, 1, 2'd1));
        load(I_ADDU, 32'd0, 32'd0);
        s1("postslot_f", 0, fet(0));
        s1("postslot_d", 0, dec());
        s1("postslot_e", 0, exe(0));
        s1("postslot_wb", 0, wbw(2'd1, 1, 0, 0, 2'd0));

        load(I_JR, 32'h100, 32'd0);
        s1("jr_f", 0, fet(0));
        s1("jr_d", 0, dec());
        s1("jr_e", 0, exe(0));
        s1("jr_wb", 0, wbw(2'd0, 0, 0, 0, 2'd0));
        load(I_UNK, 32'd0, 32'd0);
        s1("jrslot_f", 0, fet(0));
        s1("jrslot_d", 0, dec());
        s1("jrslot_e", 0, exe(0));
        s1("jrslot_wb", 0, wbw(2'd0, 0, 0, 0, 2'd3));
        s1("nohalt_f", 0, fet(0));
        s1("nohalt_d", 0, dec());
        s1("nohalt_e", 0, exe(0));
        s1("nohalt_wb", 0, wbw(2'd0, 0, 0, 0, 2'd0));

        load(I_JR, 32'd0, 32'd0);
        s1("jr0_f", 0, fet(0));
        s1("jr0_d", 0, dec());
        s1("jr0_e", 0, exe(0));
        s1("jr0_wb", 0, wbw(2'd0, 0, 0, 0, 2'd0));
        load(I_ADDU, 32'd0, 32'd0);
        s1("hslot_f", 0, fet(0));
        s1("hslot_d", 0, dec());
        s1("hslot_e", 0, exe(0));
        s1("hslot_wb", 0, wbw(2'd1, 1, 0, 0, 2'd3));
        s1("halt0", 0, hlt());
        s1("halt1", 0, hlt());
        s1("halt2", 1, hlt());

        step("rst_mid", 1, 1, 0, rst_w(), rst_w());
        load(I_SW, 32'h100, 32'h55);
        s1("swr_f", 0, fet(0));
        s1("swr_d", 0, dec());
        s1("swr_e", 0, exe(1));
        s1("swr_m", 1, mem(0, 1));
        step("swr_rst", 1, 1, 1, rst_w(), rst_w());
        s1("swr_refetch", 0, fet(0));

        step("ds0_enter", 1, 1, 0, rst_w(), rst_w());
        load(I_BEQ, 32'd7, 32'd7);
        s0("beq0_f", 0, fet(0));
        s0("beq0_d", 0, dec());
        s0("beq0_e", 0, exe(0));
        s0("beq0_wb", 0, wbw(2'd0, 0, 0, 0, 2'd1));
        load(I_ADDU, 32'd0, 32'd0);
        s0("after0_f", 0, fet(0));
        s0("after0_d", 0, dec());
        s0("after0_e", 0, exe(0));
        s0("after0_wb", 0, wbw(2'd1, 1, 0, 0, 2'd0));
        load(I_JR, 32'd0, 32'd0);
        s0("jr00_f", 0, fet(0));
        s0("jr00_d", 0, dec());
        s0("jr00_e", 0, exe(0));
        s0("jr00_wb", 0, wbw(2'd0, 0, 0, 0, 2'd3));
        load(I_ADDU, 32'd0, 32'd0);
        s0("halt00", 0, hlt());
        s0("halt01", 0, hlt());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
